// File: rtl/spike_vote_counter.sv
// Per-class spike vote accumulator with argmax, fed by the grid's synchronized spike bus.
// Optional macro SPIKE_VOTE_READBACK_EN adds a registered per-class counter readback port.
module spike_vote_counter #(
  parameter int NUM_CLASS         = 10,
  parameter int NEURONS_PER_CLASS = 25,
  parameter int CNT_W             = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CLASS*NEURONS_PER_CLASS-1:0] spike_in,
  input  logic                                   tick_in,
  input  logic                                   complete_in,
  input  logic                                   clear,
  output logic                                   busy,
  output logic [$clog2(NUM_CLASS)-1:0]           class_out,
  output logic [CNT_W-1:0]                       class_max,
  output logic                                   class_valid,
  output logic                                   overrun,
  output logic                                   saturated
`ifdef SPIKE_VOTE_READBACK_EN
  ,
  input  logic [$clog2(NUM_CLASS)-1:0]           cnt_sel,
  output logic [CNT_W-1:0]                       cnt_rdata
`endif
);

  localparam int IDX_W = $clog2(NUM_CLASS);
  localparam int POP_W = $clog2(NEURONS_PER_CLASS + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_ARGMAX, S_DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic                                   r_tick_q;
  logic                                   r_comp_q;
  logic [NUM_CLASS*NEURONS_PER_CLASS-1:0] r_snap;
  logic [NUM_CLASS*NEURONS_PER_CLASS-1:0] r_pend_reg;
  logic                                   r_pend;
  logic                                   r_cpend;
  logic [IDX_W-1:0]                       r_idx;
  logic [CNT_W-1:0]                       r_acc [NUM_CLASS];
  logic [IDX_W-1:0]                       r_best_idx;
  logic [CNT_W-1:0]                       r_best_val;
  logic                                   r_busy;
  logic [IDX_W-1:0]                       r_class_out;
  logic [CNT_W-1:0]                       r_class_max;
  logic                                   r_class_valid;
  logic                                   r_overrun;
  logic                                   r_saturated;

  logic                         w_tick_rise;
  logic                         w_comp_rise;
  logic                         w_last;
  logic [NEURONS_PER_CLASS-1:0] w_slice [NUM_CLASS];
  logic [POP_W-1:0]             w_pop;
  logic [SUM_W-1:0]             w_sum;
  logic                         w_clamp;
  logic [CNT_W-1:0]             w_acc_next;
  logic [CNT_W-1:0]             w_cur;
  logic                         w_gt;

  function automatic logic [POP_W-1:0] popcount(input logic [NEURONS_PER_CLASS-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < NEURONS_PER_CLASS; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

  for (genvar gk = 0; gk < NUM_CLASS; gk++) begin : g_slice
    assign w_slice[gk] = r_snap[gk*NEURONS_PER_CLASS +: NEURONS_PER_CLASS];
  end

  assign w_tick_rise = tick_in & ~r_tick_q;
  assign w_comp_rise = complete_in & ~r_comp_q;
  assign w_last      = (r_idx == LAST_IDX);
  assign w_pop       = popcount(w_slice[r_idx]);
  assign w_sum       = {1'b0, r_acc[r_idx]} + SUM_W'(w_pop);
  assign w_clamp     = w_sum[CNT_W];
  assign w_acc_next  = w_clamp ? CNT_MAX : w_sum[CNT_W-1:0];
  assign w_cur       = r_acc[r_idx];
  assign w_gt        = (w_cur > r_best_val);

  assign busy        = r_busy;
  assign class_out   = r_class_out;
  assign class_max   = r_class_max;
  assign class_valid = r_class_valid;
  assign overrun     = r_overrun;
  assign saturated   = r_saturated;

  // Argmax waits in IDLE until no scan is pending, so every latched vector is counted first.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_tick_rise) begin
          w_next = S_SCAN;
        end else if (r_cpend && !r_pend) begin
          w_next = S_ARGMAX;
        end
      end
      S_SCAN: begin
        if (w_last && !r_pend && !w_tick_rise) begin
          w_next = S_IDLE;
        end
      end
      S_ARGMAX: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_DONE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (clear) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_q      <= 1'b0;
      r_comp_q      <= 1'b0;
      r_snap        <= '0;
      r_pend_reg    <= '0;
      r_pend        <= 1'b0;
      r_cpend       <= 1'b0;
      r_idx         <= '0;
      r_best_idx    <= '0;
      r_best_val    <= '0;
      r_busy        <= 1'b0;
      r_class_out   <= '0;
      r_class_max   <= '0;
      r_class_valid <= 1'b0;
      r_overrun     <= 1'b0;
      r_saturated   <= 1'b0;
      for (int k = 0; k < NUM_CLASS; k++) begin
        r_acc[k] <= '0;
      end
    end else begin
      r_tick_q <= tick_in;
      r_comp_q <= complete_in;
      r_busy   <= (w_next == S_SCAN) || (w_next == S_ARGMAX);
      if (clear) begin
        r_pend        <= 1'b0;
        r_cpend       <= 1'b0;
        r_idx         <= '0;
        r_class_out   <= '0;
        r_class_max   <= '0;
        r_class_valid <= 1'b0;
        r_overrun     <= 1'b0;
        r_saturated   <= 1'b0;
        for (int k = 0; k < NUM_CLASS; k++) begin
          r_acc[k] <= '0;
        end
      end else begin
        if (w_comp_rise) begin
          r_cpend <= 1'b1;
        end
        case (r_state)
          S_IDLE: begin
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_val <= '0;
            if (w_tick_rise) begin
              r_snap <= spike_in;
            end
          end
          S_SCAN: begin
            r_acc[r_idx] <= w_acc_next;
            if (w_clamp) begin
              r_saturated <= 1'b1;
            end
            r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
            // The pending slot is freed on the last scan cycle, so a tick arriving then refills it.
            if (w_last) begin
              if (r_pend) begin
                r_snap <= r_pend_reg;
                if (w_tick_rise) begin
                  r_pend_reg <= spike_in;
                end else begin
                  r_pend <= 1'b0;
                end
              end else if (w_tick_rise) begin
                r_snap <= spike_in;
              end
            end else if (w_tick_rise) begin
              if (r_pend) begin
                r_overrun <= 1'b1;
              end else begin
                r_pend     <= 1'b1;
                r_pend_reg <= spike_in;
              end
            end
          end
          S_ARGMAX: begin
            if (w_gt) begin
              r_best_idx <= r_idx;
              r_best_val <= w_cur;
            end
            r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
            if (w_last) begin
              r_class_out   <= w_gt ? r_idx : r_best_idx;
              r_class_max   <= w_gt ? w_cur : r_best_val;
              r_class_valid <= 1'b1;
              r_cpend       <= 1'b0;
            end
            if (w_tick_rise) begin
              r_overrun <= 1'b1;
            end
          end
          S_DONE: begin
            if (w_tick_rise) begin
              r_overrun <= 1'b1;
            end
          end
          default: begin
            r_idx <= '0;
          end
        endcase
      end
    end
  end

`ifdef SPIKE_VOTE_READBACK_EN
  logic [CNT_W-1:0] r_cnt_rdata;

  assign cnt_rdata = r_cnt_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_rdata <= '0;
    end else if (int'(cnt_sel) < NUM_CLASS) begin
      r_cnt_rdata <= r_acc[cnt_sel];
    end else begin
      r_cnt_rdata <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_spike_vote_counter.sv
// Randomized self-checking bench for spike_vote_counter against a per-class vote model.
// Readback checks are compiled in when SPIKE_VOTE_READBACK_EN is defined.
module tb_spike_vote_counter;

  localparam int NC  = 10;
  localparam int NPC = 25;
  localparam int CW  = 8;
  localparam int VW  = NC * NPC;
  localparam int IW  = $clog2(NC);
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [VW-1:0] spike_in;
  logic          tick_in;
  logic          complete_in;
  logic          clear;
  logic          busy;
  logic [IW-1:0] class_out;
  logic [CW-1:0] class_max;
  logic          class_valid;
  logic          overrun;
  logic          saturated;
`ifdef SPIKE_VOTE_READBACK_EN
  logic [IW-1:0] cnt_sel;
  logic [CW-1:0] cnt_rdata;
`endif

  int nCompared   = 0;
  int nMismatched = 0;
  int refAcc [NC];
  bit refSat;
  bit refOvr;

  spike_vote_counter #(.NUM_CLASS(NC), .NEURONS_PER_CLASS(NPC), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .spike_in    (spike_in),
    .tick_in     (tick_in),
    .complete_in (complete_in),
    .clear       (clear),
    .busy        (busy),
    .class_out   (class_out),
    .class_max   (class_max),
    .class_valid (class_valid),
    .overrun     (overrun),
    .saturated   (saturated)
`ifdef SPIKE_VOTE_READBACK_EN
    ,
    .cnt_sel     (cnt_sel),
    .cnt_rdata   (cnt_rdata)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic modelClear();
    for (int k = 0; k < NC; k++) refAcc[k] = 0;
    refSat = 1'b0;
    refOvr = 1'b0;
  endtask

  task automatic modelTick(input logic [VW-1:0] v);
    for (int k = 0; k < NC; k++) begin
      int s;
      s = refAcc[k] + $countones(v[k*NPC +: NPC]);
      if (s > SAT) begin
        s = SAT;
        refSat = 1'b1;
      end
      refAcc[k] = s;
    end
  endtask

  // Winner is the largest vote total; among equal totals the lowest class wins.
  function automatic int refBestIdx();
    int mx;
    mx = 0;
    for (int k = 0; k < NC; k++) if (refAcc[k] > mx) mx = refAcc[k];
    for (int k = 0; k < NC; k++) if (refAcc[k] == mx) return k;
    return 0;
  endfunction

  function automatic logic [VW-1:0] randVec();
    logic [255:0] t;
    for (int w = 0; w < 8; w++) t[w*32 +: 32] = $urandom() & $urandom();
    return t[VW-1:0];
  endfunction

  task automatic sendTick(input logic [VW-1:0] v);
    spike_in = v;
    tick_in  = 1'b1;
    cyc();
    tick_in  = 1'b0;
  endtask

  task automatic sendClear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    modelClear();
  endtask

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    nCompared++;
    if (!ok) begin
      nMismatched++;
      $display("[TB] FAIL wait_idle busy still %0b after 200 cycles, want 0", busy);
    end
  endtask

  task automatic runComplete(output int cycles);
    complete_in = 1'b1;
    cycles = 0;
    while (!class_valid && cycles < 100) begin
      cyc();
      cycles++;
    end
    complete_in = 1'b0;
  endtask

  task automatic test_reset();
    logic [5+IW+CW-1:0] got;
    reset = 1'b1; tick_in = 1'b0; complete_in = 1'b0; clear = 1'b0; spike_in = '0;
`ifdef SPIKE_VOTE_READBACK_EN
    cnt_sel = '0;
`endif
    modelClear();
    repeat (3) @(posedge clk);
    #1;
    got = {busy, class_valid, overrun, saturated, 1'b0, class_out, class_max};
    nCompared++;
    if (got !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs got %h want 0", got);
    end
    reset = 1'b0;
    repeat (2) cyc();
    nCompared++;
    if (busy !== 1'b0 || class_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_release busy=%0b valid=%0b want 0 0", busy, class_valid);
    end
  endtask

  task automatic test_basic();
    logic [VW-1:0] v;
    int n;
    v = '0;
    v[4:0] = '1;
    v[27:25] = '1;
    modelTick(v);
    sendTick(v);
    waitIdle();
    runComplete(n);
    nCompared++;
    if (n != NC + 2) begin
      nMismatched++;
      $display("[TB] FAIL basic_latency got %0d want %0d", n, NC + 2);
    end
    nCompared++;
    if (class_valid !== 1'b1 || class_out !== IW'(refBestIdx()) || class_max !== CW'(refAcc[refBestIdx()])) begin
      nMismatched++;
      $display("[TB] FAIL basic_result valid=%0b class=%0d max=%0d want 1 %0d %0d",
               class_valid, class_out, class_max, refBestIdx(), refAcc[refBestIdx()]);
    end
    nCompared++;
    if (class_max !== 8'd5 || overrun !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL basic_const max=%0d ovr=%0b want 5 0", class_max, overrun);
    end
`ifdef SPIKE_VOTE_READBACK_EN
    cnt_sel = IW'(1);
    cyc();
    nCompared++;
    if (cnt_rdata !== CW'(refAcc[1])) begin
      nMismatched++;
      $display("[TB] FAIL readback_c1 got %0d want %0d", cnt_rdata, refAcc[1]);
    end
    cnt_sel = IW'(12);
    cyc();
    nCompared++;
    if (cnt_rdata !== '0) begin
      nMismatched++;
      $display("[TB] FAIL readback_oob got %0d want 0", cnt_rdata);
    end
`endif
    sendClear();
    nCompared++;
    if (class_valid !== 1'b0 || class_max !== '0) begin
      nMismatched++;
      $display("[TB] FAIL clear_done valid=%0b max=%0d want 0 0", class_valid, class_max);
    end
  endtask

  task automatic test_accumulate();
    logic [VW-1:0] v;
    int n;
    sendClear();
    v = '0;
    v[7*NPC +: NPC] = '1;
    v[2*NPC +: 24]  = '1;
    for (int t = 0; t < 3; t++) begin
      modelTick(v);
      sendTick(v);
      waitIdle();
    end
    runComplete(n);
    nCompared++;
    if (class_out !== IW'(7) || class_max !== CW'(75) || overrun !== 1'b0 || saturated !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL accumulate class=%0d max=%0d ovr=%0b sat=%0b want 7 75 0 0",
               class_out, class_max, overrun, saturated);
    end
  endtask

  task automatic test_tie_saturation();
    logic [VW-1:0] v;
    int n;
    sendClear();
    v = '0;
    v[3*NPC +: 10] = '1;
    v[6*NPC +: 10] = '1;
    modelTick(v);
    sendTick(v);
    waitIdle();
    runComplete(n);
    nCompared++;
    if (class_out !== IW'(3) || class_max !== CW'(10)) begin
      nMismatched++;
      $display("[TB] FAIL tie class=%0d max=%0d want 3 10", class_out, class_max);
    end
    sendClear();
    v = '0;
    v[9*NPC +: NPC] = '1;
    for (int t = 0; t < 11; t++) begin
      modelTick(v);
      sendTick(v);
      waitIdle();
    end
    runComplete(n);
    nCompared++;
    if (class_out !== IW'(9) || class_max !== CW'(SAT) || saturated !== refSat || refSat !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL saturate class=%0d max=%0d sat=%0b want 9 %0d 1", class_out, class_max, saturated, SAT);
    end
  endtask

  task automatic test_pending_overrun();
    logic [VW-1:0] v1, v2, v3;
    int n;
    sendClear();
    v1 = randVec(); v2 = randVec(); v3 = randVec();
    modelTick(v1);
    modelTick(v2);
    refOvr = 1'b1;
    sendTick(v1);
    cyc();
    sendTick(v2);
    cyc();
    sendTick(v3);
    runComplete(n);
    // Complete rises 5 edges into the first scan; the pending scan, one idle and the argmax follow.
    nCompared++;
    if (n != 2 * NC + 7) begin
      nMismatched++;
      $display("[TB] FAIL pend_latency got %0d want %0d", n, 2 * NC + 7);
    end
    nCompared++;
    if (overrun !== refOvr || class_out !== IW'(refBestIdx()) || class_max !== CW'(refAcc[refBestIdx()])) begin
      nMismatched++;
      $display("[TB] FAIL pend_result ovr=%0b class=%0d max=%0d want 1 %0d %0d",
               overrun, class_out, class_max, refBestIdx(), refAcc[refBestIdx()]);
    end
  endtask

  task automatic test_clear_reset();
    logic [VW-1:0] v;
    logic [5+IW+CW-1:0] got;
    int n;
    sendClear();
    v = randVec();
    modelTick(v);
    sendTick(v);
    waitIdle();
    complete_in = 1'b1;
    repeat (5) cyc();
    nCompared++;
    if (busy !== 1'b1 || class_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL mid_argmax busy=%0b valid=%0b want 1 0", busy, class_valid);
    end
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    complete_in = 1'b0;
    modelClear();
    got = {busy, class_valid, overrun, saturated, 1'b0, class_out, class_max};
    nCompared++;
    if (got !== '0) begin
      nMismatched++;
      $display("[TB] FAIL clear_argmax got %h want 0", got);
    end
`ifdef SPIKE_VOTE_READBACK_EN
    cnt_sel = IW'($urandom_range(0, NC - 1));
    cyc();
    nCompared++;
    if (cnt_rdata !== '0) begin
      nMismatched++;
      $display("[TB] FAIL clear_acc class %0d got %0d want 0", cnt_sel, cnt_rdata);
    end
`endif
    sendTick(randVec());
    repeat (2) cyc();
    reset = 1'b1;
    #1;
    got = {busy, class_valid, overrun, saturated, 1'b0, class_out, class_max};
    nCompared++;
    if (got !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_scan got %h want 0", got);
    end
    reset = 1'b0;
    modelClear();
    cyc();
    v = '0;
    v[4*NPC] = 1'b1;
    modelTick(v);
    sendTick(v);
    waitIdle();
    runComplete(n);
    nCompared++;
    if (class_out !== IW'(4) || class_max !== CW'(1) || class_valid !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL after_reset class=%0d max=%0d valid=%0b want 4 1 1", class_out, class_max, class_valid);
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] v;
    int n, nt, gap;
    for (int r = 0; r < 8; r++) begin
      sendClear();
      nt = $urandom_range(1, 4);
      for (int t = 0; t < nt; t++) begin
        v = randVec();
        modelTick(v);
        sendTick(v);
        if ($urandom_range(0, 1) == 1) begin
          gap = $urandom_range(2, 9);
          repeat (gap - 1) cyc();
          v = randVec();
          modelTick(v);
          sendTick(v);
        end
        waitIdle();
      end
      runComplete(n);
      nCompared++;
      if (class_valid !== 1'b1 || n != NC + 2 || class_out !== IW'(refBestIdx()) ||
          class_max !== CW'(refAcc[refBestIdx()]) || saturated !== refSat || overrun !== refOvr) begin
        nMismatched++;
        $display("[TB] FAIL random_%0d lat=%0d class=%0d max=%0d sat=%0b ovr=%0b want %0d %0d %0d %0b %0b",
                 r, n, class_out, class_max, saturated, overrun,
                 NC + 2, refBestIdx(), refAcc[refBestIdx()], refSat, refOvr);
      end
`ifdef SPIKE_VOTE_READBACK_EN
      cnt_sel = IW'($urandom_range(0, NC - 1));
      cyc();
      nCompared++;
      if (cnt_rdata !== CW'(refAcc[cnt_sel])) begin
        nMismatched++;
        $display("[TB] FAIL random_rb class %0d got %0d want %0d", cnt_sel, cnt_rdata, refAcc[cnt_sel]);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_accumulate();
    test_tie_saturation();
    test_pending_overrun();
    test_clear_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/spike_vote_counter.md
Name: spike_vote_counter

Overview:
- Downstream consumer of the 3x2 grid's synchronized 250-bit spike output, in the CPU clock domain.
- Each tick, latches the spike vector and popcounts it per output class (10 classes x 25 neurons) into saturating accumulators.
- On end of inference, runs an argmax and presents the winning class to the CPU.
- Replaces software spike counting over the wide spike bus.

Parameters:
- NUM_CLASS, 10, number of output classes.
- NEURONS_PER_CLASS, 25, spike bits per class. Class k owns bits [k*NEURONS_PER_CLASS +: NEURONS_PER_CLASS].
- CNT_W, 8, width of each per-class accumulator.

Ports:
- clk  input  1  CPU clock (sys_clk domain).
- reset  input  1  asynchronous, active-high reset.
- spike_in  input  NUM_CLASS*NEURONS_PER_CLASS  synchronized spike vector from the grid.
- tick_in  input  1  synchronized tick level; rising edge = new spike vector valid.
- complete_in  input  1  synchronized all-process-complete level; rising edge starts argmax.
- clear  input  1  synchronous clear of counters, flags and result.
- busy  output  1  high in SCAN or ARGMAX.
- class_out  output  $clog2(NUM_CLASS)  winning class index.
- class_max  output  CNT_W  vote count of the winning class.
- class_valid  output  1  level; high from argmax end until clear.
- overrun  output  1  sticky; a tick edge was lost.
- saturated  output  1  sticky; some accumulator hit all-ones.

Behaviour:
- Reset (async, active-high): state IDLE; all accumulators, registered outputs and sticky flags = 0; edge-detect registers = 0.
- Edge detect: registered copies of tick_in and complete_in. tick_rise = tick_in & ~tick_q. Same form for complete_rise.
- Latching: on tick_rise in IDLE, capture spike_in into snap_reg and go to SCAN. class_idx = 0.
- SCAN: one class per cycle.
  - acc[class_idx] += popcount(snap_reg[class_idx slice]), saturating at 2^CNT_W-1.
  - Set saturated when clamping occurs.
  - After class NUM_CLASS-1 (NUM_CLASS cycles after entry), go to IDLE.
- Tick pending:
  - A tick_rise during SCAN sets pend and captures spike_in into pend_reg.
  - Leaving SCAN with pend set moves pend_reg into snap_reg, clears pend and re-enters SCAN with no idle cycle.
  - A tick_rise while pend is already set sets overrun. That vector is dropped.
- Complete pending:
  - complete_rise sets cpend.
  - ARGMAX starts from IDLE only when cpend=1 and pend=0, so all pending scans finish first.
- ARGMAX:
  - NUM_CLASS cycles, one comparison per cycle. best starts at class 0.
  - Replace best only on strictly greater, so ties resolve to the lowest index.
  - On the final cycle, register class_out and class_max, set class_valid = 1, clear cpend, go to DONE.
- DONE: tick_rise is ignored and sets overrun. Leave only via clear.
- clear:
  - Highest priority of all events.
  - Zeroes accumulators, pend, cpend, class_valid, class_out, class_max, overrun and saturated; goes to IDLE the next cycle.
  - Takes effect in any state, including mid-SCAN or mid-ARGMAX.
- busy = (state==SCAN) | (state==ARGMAX), registered.
- Latency:
  - tick_rise to counts updated: NUM_CLASS+1 cycles.
  - complete_rise (idle, no pend) to class_valid: NUM_CLASS+2 cycles.
- Simultaneous tick_rise and complete_rise in IDLE: the scan starts, cpend is set, and argmax follows the scan.
- Popcount width is $clog2(NEURONS_PER_CLASS+1). It is zero-extended before the saturating add.

Optional Feature:
- Macro SPIKE_VOTE_READBACK_EN.
- When defined, adds two ports:
  - cnt_sel, input, $clog2(NUM_CLASS).
  - cnt_rdata, output, CNT_W. Registered read of acc[cnt_sel] with one-cycle latency. Reads 0 if cnt_sel >= NUM_CLASS. Valid in any state.
- When undefined, neither port exists and accumulators are reachable only through class_max.

Test Plan:
- Reset, then one tick with spike_in bits [0..4] set (class 0 = 5) and bits [25..27] set (class 1 = 3), then complete -> class_out=0, class_max=5, class_valid=1 exactly NUM_CLASS+2 cycles after complete_rise.
- Three ticks, each with class 7 all 25 bits and class 2 with 24 bits, then complete -> class_out=7, class_max=75, overrun=0.
- Tie: class 3 and class 6 both 10 votes -> class_out=3. 11 ticks of class 9 = 25 bits with CNT_W=8 -> class_max=255, saturated=1.
- Three tick edges spaced 2 cycles apart inside one SCAN -> first two counted, third dropped, overrun=1. Complete during SCAN -> class_valid asserted only after the pending scan ends.
- clear asserted mid-ARGMAX, and reset asserted mid-SCAN -> all outputs 0 on the next cycle (reset immediately). A following single tick with class 4 = 1 spike gives class_out=4, class_max=1.
- With SPIKE_VOTE_READBACK_EN: cnt_sel=1 after the first scenario -> cnt_rdata=3 one cycle later. cnt_sel=12 -> 0.
